// File: rtl/arb_rr.sv
// Round-robin / fixed-priority output arbiter: grant held until the holder drops req.
// Grant one cycle after req; zero-gap handover on release; optional hold limit forces handover.
module arb_rr #(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [IDXW-1:0] lead,
  output logic            preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int SW = IDXW + 1;
  localparam logic [CNTW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNTW'(MAX_HOLD - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;

  state_t          state_q, state_d;
  logic [IDXW-1:0] gnt_d, lead_d;
  logic [CNTW-1:0] hold_cnt, cnt_d;
  logic            pre_d;

  logic [N-1:0]    cand;
  logic [N-1:0]    rot;
  logic            holder_req;
  logic            pick_any;
  logic [IDXW-1:0] pick_idx;
  logic [SW-1:0]   wsum;
  logic            load;

  assign gnt_valid = (state_q == GRANT);

  always_comb begin
    ack = '0;
    for (int i = 0; i < N; i++) begin
      ack[i] = req[i] & gnt_valid & (gnt_idx == IDXW'(i));
    end
  end

  // Candidates: every requester except the current holder.
  always_comb begin
    cand       = req;
    holder_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_valid && gnt_idx == IDXW'(i)) begin
        cand[i]    = 1'b0;
        holder_req = req[i];
      end
    end
  end

  // Rotate so bit k holds candidate (lead+k) mod N; lead is always < N.
  always_comb begin
    rot      = N'({cand, cand} >> lead);
    pick_any = |cand;
    pick_idx = '0;
    wsum     = '0;
    if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i]) pick_idx = IDXW'(i);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) wsum = {1'b0, lead} + SW'(k);
      end
      if (wsum >= SW'(N)) wsum = wsum - SW'(N);
      pick_idx = wsum[IDXW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_idx;
    lead_d  = lead;
    cnt_d   = hold_cnt;
    pre_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          load    = 1'b1;
        end
      end
      GRANT: begin
        if (!holder_req) begin
          if (pick_any) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && pick_any) begin
          load  = 1'b1;
          pre_d = 1'b1;
        end else if (hold_cnt != CNT_MAX) begin
          cnt_d = hold_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      gnt_d  = pick_idx;
      cnt_d  = '0;
      lead_d = (pick_idx == IDXW'(N - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_idx  <= '0;
      lead     <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_idx  <= gnt_d;
      lead     <= lead_d;
      hold_cnt <= cnt_d;
      preempt  <= pre_d;
    end
  end

endmodule
